rv_plic_gateway_claim: RTL and testbench

RV_PLIC_GATEWAY_CLAIM -- requirements
Module: rv_plic_gateway_claim

---
 rtl/rv_plic_gateway_claim.sv | 117 +++++++++++
 tb/tb_rv_plic_gateway_claim.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_plic_gateway_claim.sv
// PLIC gateway with per-source IDLE/PENDING/CLAIMED tracking, a deferred-edge
// bit for edges seen while claimed, and a three-phase claim/response handshake.
module rv_plic_gateway_claim #(
  parameter  int N_SOURCE = 32,
  localparam int SrcWidth = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  output logic [N_SOURCE-1:0] ip_o,
  input  logic                target_irq_i,
  input  logic [SrcWidth-1:0] target_id_i,
  input  logic                claim_req_i,
  output logic                claim_rdy_o,
  output logic                claim_vld_o,
  output logic [SrcWidth-1:0] claim_id_o,
  input  logic                claim_ack_i,
  input  logic                complete_i,
  input  logic [SrcWidth-1:0] complete_id_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_CLMD = 2'd2;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CAPT = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  logic [N_SOURCE-1:0][1:0]   st_q, st_d;
  logic [N_SOURCE-1:0]        defer_q, defer_d;
  logic [N_SOURCE-1:0]        src_q;
  logic [1:0]                 cst_q, cst_d;
  logic [SrcWidth-1:0]        cid_q, cid_d;

  logic [N_SOURCE-1:0]        edge_v, trig_v;
  logic [N_SOURCE-1:0]        cap_sel, cmp_sel;
  logic                       cap_hit;

  assign edge_v = le_i & src_i & ~src_q;
  assign trig_v = edge_v | (~le_i & src_i);

  // One-hot capture/complete selects; source 0 is never selectable.
  always_comb begin
    cap_sel = '0;
    cmp_sel = '0;
    for (int i = 1; i < N_SOURCE; i++) begin
      cap_sel[i] = (cst_q == C_CAPT) && target_irq_i &&
                   (target_id_i == SrcWidth'(i)) && (st_q[i] == S_PEND);
      cmp_sel[i] = complete_i && (complete_id_i == SrcWidth'(i));
    end
  end

  assign cap_hit = |cap_sel;

  always_comb begin
    st_d    = st_q;
    defer_d = defer_q;
    for (int i = 1; i < N_SOURCE; i++) begin
      unique case (st_q[i])
        S_IDLE: if (trig_v[i]) st_d[i] = S_PEND;
        S_PEND: if (cap_sel[i]) st_d[i] = S_CLMD;
        S_CLMD: begin
          // An edge arriving in the completion cycle is kept, not dropped.
          if (cmp_sel[i]) begin
            st_d[i]    = (defer_q[i] || edge_v[i]) ? S_PEND : S_IDLE;
            defer_d[i] = 1'b0;
          end else if (edge_v[i]) begin
            defer_d[i] = 1'b1;
          end
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cst_d = cst_q;
    cid_d = cid_q;
    unique case (cst_q)
      C_IDLE: if (claim_req_i) cst_d = C_CAPT;
      C_CAPT: begin
        cst_d = C_RESP;
        cid_d = cap_hit ? target_id_i : '0;
      end
      C_RESP: if (claim_ack_i) cst_d = C_IDLE;
      default: cst_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= '0;
      defer_q <= '0;
      src_q   <= '0;
      cst_q   <= C_IDLE;
      cid_q   <= '0;
    end else begin
      st_q    <= st_d;
      defer_q <= defer_d;
      src_q   <= src_i;
      cst_q   <= cst_d;
      cid_q   <= cid_d;
    end
  end

  always_comb begin
    ip_o = '0;
    for (int i = 1; i < N_SOURCE; i++) ip_o[i] = (st_q[i] == S_PEND);
  end

  assign claim_rdy_o = (cst_q == C_IDLE);
  assign claim_vld_o = (cst_q == C_RESP);
  assign claim_id_o  = claim_vld_o ? cid_q : '0;

endmodule

// File: tb/tb_rv_plic_gateway_claim.sv
// Directed scenarios plus randomized traffic against a source-level reference
// model; claim responses are checked through an expected-ID queue.
module tb_rv_plic_gateway_claim;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src, le, ip_o;
  logic       tirq, creq, ack, cmp;
  logic [2:0] tid, cid, claim_id_o;
  logic       claim_rdy_o, claim_vld_o;

  rv_plic_gateway_claim #(.N_SOURCE(N)) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .ip_o(ip_o),
    .target_irq_i(tirq), .target_id_i(tid),
    .claim_req_i(creq), .claim_rdy_o(claim_rdy_o), .claim_vld_o(claim_vld_o),
    .claim_id_o(claim_id_o), .claim_ack_i(ack),
    .complete_i(cmp), .complete_id_i(cid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: 0 = idle, 1 = pending, 2 = claimed; mph tracks the
  // handshake phase (0 free, 1 capture pending, 2 response out).
  int       mst[N];
  bit       mdef[N], mprev[N];
  int       mph;
  int       exp_q[$];
  bit [7:0] m_ip;
  int       old_st[N];
  bit       done_v[N];
  int       cap_id;
  bit       rise;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin mst[i] = 0; mdef[i] = 0; mprev[i] = 0; end
      mph = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin old_st[i] = mst[i]; done_v[i] = 0; end
      if (mph == 1) begin
        cap_id = (tirq && tid != 0 && old_st[tid] == 1) ? int'(tid) : 0;
        exp_q.push_back(cap_id);
        if (cap_id != 0) mst[cap_id] = 2;
      end
      if (cmp && cid >= 1 && old_st[cid] == 2) begin
        mst[cid]    = (mdef[cid] || (le[cid] && src[cid] && !mprev[cid])) ? 1 : 0;
        mdef[cid]   = 0;
        done_v[cid] = 1;
      end
      for (int i = 1; i < N; i++) begin
        rise = src[i] && !mprev[i];
        if (old_st[i] == 0 && (le[i] ? rise : src[i])) mst[i] = 1;
        else if (old_st[i] == 2 && !done_v[i] && le[i] && rise) mdef[i] = 1;
      end
      for (int i = 0; i < N; i++) mprev[i] = src[i];
      case (mph)
        0: if (creq) mph = 1;
        1: mph = 2;
        default: if (ack) mph = 0;
      endcase
    end
    for (int i = 0; i < N; i++) m_ip[i] = (mst[i] == 1);
  end

  // Monitor: compares DUT outputs with the model and drains the claim queue.
  bit       mon_en = 0;
  bit       vld_prev = 0;
  int       held_id = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("ip_o", ip_o, m_ip);
      check("claim_rdy", claim_rdy_o, mph == 0);
      check("claim_vld", claim_vld_o, mph == 2);
      if (claim_vld_o) begin
        if (!vld_prev) begin
          check("claim_q_len", exp_q.size(), 1);
          if (exp_q.size() != 0) held_id = exp_q.pop_front();
          check("claim_id", claim_id_o, held_id);
        end else begin
          check("claim_id_hold", claim_id_o, held_id);
        end
      end else begin
        check("claim_id_zero", claim_id_o, 0);
      end
      vld_prev = claim_vld_o;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic complete(input int id);
    cmp = 1; cid = 3'(id); tick(); cmp = 0;
  endtask

  // Request at T, capture at T+1 (optional concurrent completion), response
  // from T+2 held for 'hold' extra cycles with requests asserted meanwhile.
  task automatic do_claim(input bit irq, input int id, input int cmp_id,
                          input int hold, input int exp_id);
    tirq = irq; tid = 3'(id); creq = 1; tick();
    creq = 0;
    if (cmp_id >= 0) begin cmp = 1; cid = 3'(cmp_id); end
    tick();
    cmp = 0;
    @(negedge clk);
    check("dir_claim_id", claim_id_o, exp_id);
    check("dir_claim_vld", claim_vld_o, 1);
    creq = (hold > 0);
    repeat (hold) tick();
    if (hold > 0) check("dir_hold_rdy", claim_rdy_o, 0);
    ack = 1; tick(); ack = 0; creq = 0;
  endtask

  function automatic int pick(input int want);
    int s = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++) begin
      int j = (s + k) % N;
      if (j != 0 && mst[j] == want) return j;
    end
    return $urandom_range(0, N - 1);
  endfunction

  initial begin
    rst = 1; src = 0; le = 0; tirq = 0; tid = 0; creq = 0; ack = 0; cmp = 0; cid = 0;
    @(posedge clk); #1; mon_en = 1;
    tick(2); rst = 0;
    @(negedge clk);
    check("rst_ip", ip_o, 8'h00);
    check("rst_rdy", claim_rdy_o, 1);

    // Level source 3: pend, claim with a held response, complete while high.
    src[3] = 1; tick();
    @(negedge clk); check("lvl_pend", ip_o, 8'h08);
    do_claim(1, 3, -1, 4, 3);
    check("lvl_claimed", ip_o[3], 0);
    complete(3);
    @(negedge clk); check("lvl_idle_gap", ip_o[3], 0);
    tick();
    @(negedge clk); check("lvl_repend", ip_o[3], 1);
    src[3] = 0; tick();
    do_claim(1, 3, -1, 0, 3);
    complete(3);

    // Edge source 5: two pulses while claimed collapse into one deferred edge.
    le[5] = 1; src[5] = 1; tick(); src[5] = 0; tick();
    do_claim(1, 5, -1, 0, 5);
    src[5] = 1; tick(); src[5] = 0; tick(); src[5] = 1; tick(); src[5] = 0; tick();
    complete(5);
    @(negedge clk); check("edge_defer", ip_o[5], 1);
    do_claim(1, 5, -1, 0, 5);
    complete(5);
    @(negedge clk); check("edge_idle", ip_o[5], 0);

    // Null claims.
    do_claim(0, 3, -1, 0, 0);
    do_claim(1, 6, -1, 0, 0);

    // Ignored completions, then completion concurrent with a capture.
    complete(0); complete(2);
    src[4] = 1; tick(); src[4] = 0;
    complete(4);
    @(negedge clk); check("cmp_ignored", ip_o, 8'h10);
    src[7] = 1; src[2] = 1; tick(); src[7] = 0; src[2] = 0;
    do_claim(1, 7, -1, 0, 7);
    do_claim(1, 2, 7, 0, 2);
    @(negedge clk); check("cmp_and_capt", ip_o, 8'h10);

    // Reset while in capture.
    src[1] = 1; src[3] = 1; tick(); src[1] = 0; src[3] = 0;
    tirq = 1; tid = 1; creq = 1; tick();
    creq = 0; rst = 1; tick(); rst = 0;
    @(negedge clk);
    check("rst_capt_ip", ip_o, 8'h00);
    check("rst_capt_rdy", claim_rdy_o, 1);
    check("rst_capt_vld", claim_vld_o, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      src  = src ^ 8'($urandom & $urandom);
      if ($urandom_range(0, 49) == 0) le = 8'($urandom);
      creq = ($urandom_range(0, 2) == 0);
      ack  = 1'($urandom_range(0, 1));
      cmp  = ($urandom_range(0, 3) == 0);
      cid  = 3'(($urandom_range(0, 9) < 7) ? pick(2) : $urandom_range(0, N - 1));
      tirq = ($urandom_range(0, 5) != 0);
      tid  = 3'(($urandom_range(0, 3) != 0) ? pick(1) : $urandom_range(0, N - 1));
      tick();
    end

    rst = 0; creq = 0; cmp = 0; ack = 1;
    tick(5);
    ack = 0;
    @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
